// File: rtl/decoder_pipe.sv
// Pipelined RV32I + Zicsr instruction decoder with valid/ready handshake, flush and retired-decode counter.
// Optional M extension decode is enabled by defining DECODER_RV32M_EN.

package decoder_pkg;

    typedef enum logic [5:0] {
        i_NOP,
        i_LUI, i_AUIPC, i_JAL, i_JALR,
        i_BEQ, i_BNE, i_BLT, i_BGE, i_BLTU, i_BGEU,
        i_LB, i_LH, i_LW, i_LBU, i_LHU,
        i_SB, i_SH, i_SW,
        i_ADDI, i_SLTI, i_SLTIU, i_XORI, i_ORI, i_ANDI, i_SLLI, i_SRLI, i_SRAI,
        i_ADD, i_SUB, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_SRA, i_OR, i_AND,
        i_FENCE, i_ECALL, i_EBREAK, i_MRET,
        i_CSRRW, i_CSRRS, i_CSRRC, i_CSRRWI, i_CSRRSI, i_CSRRCI,
        i_MUL, i_MULH, i_MULHSU, i_MULHU, i_DIV, i_DIVU, i_REM, i_REMU
    } opcodes_t;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_U, FMT_I, FMT_R, FMT_B, FMT_S, FMT_J
    } fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Major-opcode to format class; FMT_NONE marks an unknown (illegal) opcode.
    function automatic fmt_t classify(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC:                                    classify = FMT_U;
            OPC_JAL:                                               classify = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISC, OPC_SYSTEM:   classify = FMT_I;
            OPC_OP:                                                classify = FMT_R;
            OPC_BRANCH:                                            classify = FMT_B;
            OPC_STORE:                                             classify = FMT_S;
            default:                                               classify = FMT_NONE;
        endcase
    endfunction

endpackage

module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int IF_LEN      = 32,
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [IF_LEN-1:0]     instruction,
    input  logic [XLEN-1:0]       i_address,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       imm,
    output logic [XLEN-1:0]       o_address,
    output opcodes_t              opcode,
    output logic                  illegal,
    output logic [CNT_W-1:0]      decoded_cnt
);

    typedef struct packed {
        opcodes_t              op;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       imm;
        logic                  illegal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] w, input fmt_t fmt);
        dec_t        d;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm32;
        logic        legal;
        logic        priv;
        opcodes_t    op;
        // NOTE: every local gets a value before the case tree, so no path leaves one unassigned and no latch is inferred.
        f3    = w[14:12];
        f7    = w[31:25];
        imm32 = '0;
        legal = 1'b1;
        priv  = 1'b0;
        op    = i_NOP;
        case (fmt)
            FMT_U: op = (w[6:0] == OPC_LUI) ? i_LUI : i_AUIPC;
            FMT_J: op = i_JAL;
            FMT_B:
                case (f3)
                    3'b000:  op = i_BEQ;
                    3'b001:  op = i_BNE;
                    3'b100:  op = i_BLT;
                    3'b101:  op = i_BGE;
                    3'b110:  op = i_BLTU;
                    3'b111:  op = i_BGEU;
                    default: legal = 1'b0;
                endcase
            FMT_S:
                case (f3)
                    3'b000:  op = i_SB;
                    3'b001:  op = i_SH;
                    3'b010:  op = i_SW;
                    default: legal = 1'b0;
                endcase
            FMT_I:
                case (w[6:0])
                    OPC_JALR: if (f3 == 3'b000) op = i_JALR; else legal = 1'b0;
                    OPC_MISC: if (f3 == 3'b000) op = i_FENCE; else legal = 1'b0;
                    OPC_LOAD:
                        case (f3)
                            3'b000:  op = i_LB;
                            3'b001:  op = i_LH;
                            3'b010:  op = i_LW;
                            3'b100:  op = i_LBU;
                            3'b101:  op = i_LHU;
                            default: legal = 1'b0;
                        endcase
                    OPC_OPIMM:
                        case (f3)
                            3'b000:  op = i_ADDI;
                            3'b010:  op = i_SLTI;
                            3'b011:  op = i_SLTIU;
                            3'b100:  op = i_XORI;
                            3'b110:  op = i_ORI;
                            3'b111:  op = i_ANDI;
                            3'b001:  if (f7 == 7'b0000000) op = i_SLLI; else legal = 1'b0;
                            default:
                                if (f7 == 7'b0000000)      op = i_SRLI;
                                else if (f7 == 7'b0100000) op = i_SRAI;
                                else                       legal = 1'b0;
                        endcase
                    OPC_SYSTEM:
                        case (f3)
                            3'b000: begin
                                // Privileged ops carry no register or immediate payload downstream.
                                priv = 1'b1;
                                case (w[31:20])
                                    12'h000: op = i_ECALL;
                                    12'h001: op = i_EBREAK;
                                    12'h302: op = i_MRET;
                                    default: legal = 1'b0;
                                endcase
                            end
                            3'b001:  op = i_CSRRW;
                            3'b010:  op = i_CSRRS;
                            3'b011:  op = i_CSRRC;
                            3'b101:  op = i_CSRRWI;
                            3'b110:  op = i_CSRRSI;
                            3'b111:  op = i_CSRRCI;
                            default: legal = 1'b0;
                        endcase
                    default: legal = 1'b0;
                endcase
            FMT_R:
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  op = i_ADD;
                        3'b001:  op = i_SLL;
                        3'b010:  op = i_SLT;
                        3'b011:  op = i_SLTU;
                        3'b100:  op = i_XOR;
                        3'b101:  op = i_SRL;
                        3'b110:  op = i_OR;
                        default: op = i_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    case (f3)
                        3'b000:  op = i_SUB;
                        3'b101:  op = i_SRA;
                        default: legal = 1'b0;
                    endcase
`ifdef DECODER_RV32M_EN
                end else if (f7 == 7'b0000001) begin
                    case (f3)
                        3'b000:  op = i_MUL;
                        3'b001:  op = i_MULH;
                        3'b010:  op = i_MULHSU;
                        3'b011:  op = i_MULHU;
                        3'b100:  op = i_DIV;
                        3'b101:  op = i_DIVU;
                        3'b110:  op = i_REM;
                        default: op = i_REMU;
                    endcase
`endif
                end else begin
                    legal = 1'b0;
                end
            default: legal = 1'b0;
        endcase

        d.op      = i_NOP;
        d.rs1     = '0;
        d.rs2     = '0;
        d.rd      = '0;
        d.illegal = !legal;
        if (legal) begin
            d.op = op;
            case (fmt)
                FMT_U: begin
                    d.rd  = REG_ADDR_W'(w[11:7]);
                    imm32 = {w[31:12], 12'b0};
                end
                FMT_J: begin
                    d.rd  = REG_ADDR_W'(w[11:7]);
                    imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                end
                FMT_I: begin
                    if (!priv) begin
                        d.rd  = REG_ADDR_W'(w[11:7]);
                        d.rs1 = REG_ADDR_W'(w[19:15]);
                        imm32 = {{20{w[31]}}, w[31:20]};
                    end
                end
                FMT_R: begin
                    d.rd  = REG_ADDR_W'(w[11:7]);
                    d.rs1 = REG_ADDR_W'(w[19:15]);
                    d.rs2 = REG_ADDR_W'(w[24:20]);
                end
                FMT_B: begin
                    d.rs1 = REG_ADDR_W'(w[19:15]);
                    d.rs2 = REG_ADDR_W'(w[24:20]);
                    imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                end
                FMT_S: begin
                    d.rs1 = REG_ADDR_W'(w[19:15]);
                    d.rs2 = REG_ADDR_W'(w[24:20]);
                    imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
                end
                default: ;
            endcase
        end
        d.imm = XLEN'($signed(imm32));
        return d;
    endfunction

    logic              src_valid;
    logic [IF_LEN-1:0] src_word;
    logic [XLEN-1:0]   src_pc;
    fmt_t              src_fmt;
    logic              out_free;
    dec_t              dec;

    // The output stage can take a new word when it is empty or its current word leaves this cycle.
    assign out_free = !o_valid || i_ready;

    generate
        if (PIPE_STAGES == 2) begin : g_predecode
            logic              s1_valid;
            logic [IF_LEN-1:0] s1_word;
            logic [XLEN-1:0]   s1_pc;
            fmt_t              s1_fmt;

            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_word  <= '0;
                    s1_pc    <= '0;
                    s1_fmt   <= FMT_NONE;
                end else if (clk_en) begin
                    if (flush) begin
                        s1_valid <= 1'b0;
                    end else if (o_ready) begin
                        s1_valid <= i_valid;
                        if (i_valid) begin
                            s1_word <= instruction;
                            s1_pc   <= i_address;
                            s1_fmt  <= classify(instruction[6:0]);
                        end
                    end
                end
            end

            assign src_valid = s1_valid;
            assign src_word  = s1_word;
            assign src_pc    = s1_pc;
            assign src_fmt   = s1_fmt;
            assign o_ready   = !s1_valid || out_free;
        end else begin : g_direct
            assign src_valid = i_valid;
            assign src_word  = instruction;
            assign src_pc    = i_address;
            assign src_fmt   = classify(instruction[6:0]);
            assign o_ready   = out_free;
        end
    endgenerate

    assign dec = decode(src_word[31:0], src_fmt);

    // NOTE: payload registers are reset as well, because the outputs must read as defined values right after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid   <= 1'b0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            imm       <= '0;
            o_address <= '0;
            opcode    <= i_NOP;
            illegal   <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                o_valid <= 1'b0;
            end else if (out_free) begin
                o_valid <= src_valid;
                if (src_valid) begin
                    rs1       <= dec.rs1;
                    rs2       <= dec.rs2;
                    rd        <= dec.rd;
                    imm       <= dec.imm;
                    o_address <= src_pc;
                    opcode    <= dec.op;
                    illegal   <= dec.illegal;
                end
            end
        end
    end

    // Counts retired legal decodes; a handshake coinciding with flush still counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            decoded_cnt <= '0;
        end else if (clk_en && o_valid && i_ready && !illegal) begin
            decoded_cnt <= decoded_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed self-checking bench for decoder_pipe (default two-stage build); M-extension
// expectations follow DECODER_RV32M_EN.

module tb_decoder_pipe;
    import decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] instruction;
    logic [31:0] i_address;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] o_address;
    opcodes_t    opcode;
    logic        illegal;
    logic [31:0] decoded_cnt;

    decoder_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .flush       (flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .instruction (instruction),
        .i_address   (i_address),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm         (imm),
        .o_address   (o_address),
        .opcode      (opcode),
        .illegal     (illegal),
        .decoded_cnt (decoded_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        opcodes_t    op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t        vec [10];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_cnt      = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Outputs are driven 1 time unit after the rising edge and sampled 2 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx);
        i_valid     = 1'b1;
        instruction = vec[idx].word;
        i_address   = vec[idx].addr;
    endtask

    task automatic check_vec(input int idx);
        check($sformatf("v%0d.valid", idx),   64'(o_valid),   64'(1'b1));
        check($sformatf("v%0d.op", idx),      64'(opcode),    64'(vec[idx].op));
        check($sformatf("v%0d.rd", idx),      64'(rd),        64'(vec[idx].rd));
        check($sformatf("v%0d.rs1", idx),     64'(rs1),       64'(vec[idx].rs1));
        check($sformatf("v%0d.rs2", idx),     64'(rs2),       64'(vec[idx].rs2));
        check($sformatf("v%0d.imm", idx),     64'(imm),       64'(vec[idx].imm));
        check($sformatf("v%0d.addr", idx),    64'(o_address), 64'(vec[idx].addr));
        check($sformatf("v%0d.illegal", idx), 64'(illegal),   64'(vec[idx].ill));
    endtask

    // Back-to-back stream with i_ready=1: one accepted word and one result per cycle, latency 2.
    task automatic run_seq(input int first, input int n);
        for (int c = 0; c < n + 2; c++) begin
            cyc();
            if (c < n) drive(first + c);
            else       i_valid = 1'b0;
            #2;
            if (c < n)  check("seq.o_ready", 64'(o_ready), 64'(1'b1));
            if (c >= 2) check_vec(first + c - 2);
        end
        cyc();
        #2;
        check("seq.drained", 64'(o_valid), 64'(1'b0));
        for (int k = 0; k < n; k++)
            if (!vec[first + k].ill) exp_cnt++;
        check("seq.cnt", 64'(decoded_cnt), 64'(exp_cnt));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".o_valid"}, 64'(o_valid),     64'(1'b0));
        check({tag, ".o_ready"}, 64'(o_ready),     64'(1'b1));
        check({tag, ".rs1"},     64'(rs1),         64'(0));
        check({tag, ".rs2"},     64'(rs2),         64'(0));
        check({tag, ".rd"},      64'(rd),          64'(0));
        check({tag, ".imm"},     64'(imm),         64'(0));
        check({tag, ".addr"},    64'(o_address),   64'(0));
        check({tag, ".op"},      64'(opcode),      64'(i_NOP));
        check({tag, ".illegal"}, 64'(illegal),     64'(1'b0));
        check({tag, ".cnt"},     64'(decoded_cnt), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec[0] = '{32'hFFF10093, 32'h100, i_ADDI,  5'd1,  5'd2, 5'd0, 32'hFFFFFFFF, 1'b0};
        vec[1] = '{32'hFE208EE3, 32'h200, i_BEQ,   5'd0,  5'd1, 5'd2, 32'hFFFFFFFC, 1'b0};
        vec[2] = '{32'h00532423, 32'h204, i_SW,    5'd0,  5'd6, 5'd5, 32'h00000008, 1'b0};
        vec[3] = '{32'h001000EF, 32'h208, i_JAL,   5'd1,  5'd0, 5'd0, 32'h00000800, 1'b0};
`ifdef DECODER_RV32M_EN
        vec[4] = '{32'h022081B3, 32'h400, i_MUL,   5'd3,  5'd1, 5'd2, 32'h00000000, 1'b0};
`else
        vec[4] = '{32'h022081B3, 32'h400, i_NOP,   5'd0,  5'd0, 5'd0, 32'h00000000, 1'b1};
`endif
        vec[5] = '{32'hFFFFFFFF, 32'h500, i_NOP,   5'd0,  5'd0, 5'd0, 32'h00000000, 1'b1};
        vec[6] = '{32'h00000000, 32'h504, i_NOP,   5'd0,  5'd0, 5'd0, 32'h00000000, 1'b1};
        vec[7] = '{32'h00000073, 32'h508, i_ECALL, 5'd0,  5'd0, 5'd0, 32'h00000000, 1'b0};
        vec[8] = '{32'h30200073, 32'h50C, i_MRET,  5'd0,  5'd0, 5'd0, 32'h00000000, 1'b0};
        vec[9] = '{32'h12345537, 32'h510, i_LUI,   5'd10, 5'd0, 5'd0, 32'h12345000, 1'b0};

        rst_n       = 1'b0;
        clk_en      = 1'b1;
        flush       = 1'b0;
        i_valid     = 1'b0;
        i_ready     = 1'b1;
        instruction = '0;
        i_address   = '0;
        repeat (2) cyc();
        #2;
        check_reset_state("reset");
        cyc();
        rst_n = 1'b1;

        // Single ADDI, then BEQ/SW/JAL back-to-back.
        run_seq(0, 1);
        run_seq(1, 3);

        // Backpressure: 4 words offered while i_ready=0 for 5 cycles, then released.
        begin
            int in_idx  = 0;
            int out_idx = 0;
            for (int c = 0; c < 12; c++) begin
                cyc();
                i_ready = (c >= 5);
                if (in_idx < 4) drive(in_idx);
                else            i_valid = 1'b0;
                #2;
                if (c >= 2 && c < 5) begin
                    check("bp.o_ready_low", 64'(o_ready),   64'(1'b0));
                    check("bp.accepted",    64'(in_idx),    64'(2));
                    check("bp.hold_valid",  64'(o_valid),   64'(1'b1));
                    check("bp.hold_addr",   64'(o_address), 64'(vec[0].addr));
                    check("bp.hold_imm",    64'(imm),       64'(vec[0].imm));
                end
                if (o_valid && i_ready && out_idx < 4) begin
                    check_vec(out_idx);
                    out_idx++;
                end
                if (i_valid && o_ready) in_idx++;
            end
            check("bp.all_out", 64'(out_idx), 64'(4));
            check("bp.all_in",  64'(in_idx),  64'(4));
            exp_cnt += 4;
            check("bp.cnt", 64'(decoded_cnt), 64'(exp_cnt));
        end

        // M-extension encoding, then illegal words, privileged ops and LUI.
        run_seq(4, 1);
        run_seq(5, 5);

        // clk_en=0 freezes the held result and ignores a simultaneous flush.
        cyc(); drive(0); #2;
        cyc(); i_valid = 1'b0; #2;
        cyc(); #2;
        clk_en = 1'b0;
        flush  = 1'b1;
        cyc(); #2;
        check("stall.valid", 64'(o_valid),     64'(1'b1));
        check("stall.addr",  64'(o_address),   64'(vec[0].addr));
        check("stall.cnt",   64'(decoded_cnt), 64'(exp_cnt));
        clk_en = 1'b1;
        flush  = 1'b0;
        cyc(); #2;
        exp_cnt++;
        check("stall.release_valid", 64'(o_valid),     64'(1'b0));
        check("stall.release_cnt",   64'(decoded_cnt), 64'(exp_cnt));

        // Flush with two words in flight plus one offered; the output word hands off in the flush cycle.
        cyc(); drive(1); #2;
        cyc(); drive(2); #2;
        cyc(); drive(3); flush = 1'b1; #2;
        check("flush.emit_addr", 64'(o_address), 64'(vec[1].addr));
        cyc(); flush = 1'b0; i_valid = 1'b0; #2;
        exp_cnt++;
        check("flush.valid",   64'(o_valid),     64'(1'b0));
        check("flush.o_ready", 64'(o_ready),     64'(1'b1));
        check("flush.cnt",     64'(decoded_cnt), 64'(exp_cnt));
        for (int c = 0; c < 3; c++) begin
            cyc(); #2;
            check("flush.no_emit", 64'(o_valid), 64'(1'b0));
        end

        // Reset mid-stream discards everything.
        cyc(); drive(1); #2;
        cyc(); drive(2); #2;
        cyc(); rst_n = 1'b0; i_valid = 1'b0; #2;
        cyc(); #2;
        check_reset_state("midreset");
        rst_n   = 1'b1;
        exp_cnt = '0;
        run_seq(9, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
